key_debounce: RTL and testbench

- Front-end conditioner for mechanical push-buttons on the 50 MHz board clock.
- Synchronises a raw asynchronous key input and debounces it with a stable-time counter FSM.
- Produces a clean level, a one-cycle press pulse and a one-cycle release pulse.
- KEY_PRESS drives the SP input of the single-pulse/LED step generator directly downstream, which edge-detects it.

---
 rtl/key_debounce.sv | 167 ++++++++++++++++
 tb/tb_key_debounce.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser plus stable-time debounce FSM.
// Emits a clean level and one-cycle press/release pulses. Define KEY_REPEAT_EN for held-key auto-repeat.
module key_debounce #(
    parameter int unsigned STABLE_COUNT  = 1000000,
    parameter bit          ACTIVE_LOW    = 1'b1
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
`endif
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic KEY,
    output logic KEY_LEVEL,
    output logic KEY_PRESS,
    output logic KEY_RELEASE
);

    localparam int CNT_W = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        DOWN,
        RELEASE_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             pressed;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ ACTIVE_LOW;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Any opposite sample in a WAIT state drops back to the stable state with no credit kept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign accept    = (state_q == PRESS_WAIT) && (state_d == DOWN);
    assign level_d   = (state_d == DOWN) || (state_d == RELEASE_WAIT);
    assign release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int          RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_tgt;
    logic             rpt_armed_q, rpt_armed_d;
    logic             rpt_fire;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    assign rpt_tgt = rpt_armed_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);

    // Counting spans RELEASE_WAIT bounces; a repeat that falls due mid-bounce is skipped.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        if (state_q == DOWN || state_q == RELEASE_WAIT) begin
            if (rpt_cnt_q == rpt_tgt) begin
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
                rpt_fire    = (state_q == DOWN) && (state_d == DOWN);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end else begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end
    end

    // Never assert on back-to-back cycles so the downstream edge detector sees every pulse.
    assign press_d = accept || (rpt_fire && !press_q);
`else
    assign press_d = accept;
`endif

    assign KEY_LEVEL   = level_q;
    assign KEY_PRESS   = press_q;
    assign KEY_RELEASE = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, hand-written corner sequences and random bounce
// against a window-based reference model (level flips once SC+1 consecutive samples disagree).
module tb_key_debounce;

    localparam int SC = 4;
`ifdef KEY_REPEAT_EN
    localparam int RD = 10;
    localparam int RP = 5;
`endif

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    logic KEY  = 1'b1;
    logic KEY0 = 1'b0;
    logic lvl, prs, rel, lvl0, prs0, rel0;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    key_debounce #(
        .STABLE_COUNT(SC),
        .ACTIVE_LOW  (1'b1)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .KEY        (KEY),
        .KEY_LEVEL  (lvl),
        .KEY_PRESS  (prs),
        .KEY_RELEASE(rel)
    );

    key_debounce #(
        .STABLE_COUNT(SC),
        .ACTIVE_LOW  (1'b0)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut0 (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .KEY        (KEY0),
        .KEY_LEVEL  (lvl0),
        .KEY_PRESS  (prs0),
        .KEY_RELEASE(rel0)
    );

    typedef struct {
        logic pressed;
        logic e_lvl;
        logic e_prs;
        logic e_rel;
    } vec_t;
    vec_t tbl[40];

    // Reference model for the active-low instance.
    logic m_s1, m_s2, m_level, m_prev, e_prs, e_rel;
    int   m_held;
    logic hist[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1    = 1'b1;
        m_s2    = 1'b1;
        m_level = 1'b0;
        m_prev  = 1'b0;
        m_held  = 0;
        e_prs   = 1'b0;
        e_rel   = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge(input logic k);
        logic samp, flip;
        samp  = ~m_s2;
        m_s2  = m_s1;
        m_s1  = k;
        e_prs = 1'b0;
        e_rel = 1'b0;
        hist.push_back(samp);
        if (hist.size() > SC + 1) void'(hist.pop_front());
        flip = (hist.size() == SC + 1);
        foreach (hist[i]) if (hist[i] == m_level) flip = 1'b0;
        if (flip) begin
            m_level = ~m_level;
            if (m_level) begin
                e_prs  = 1'b1;
                m_held = 0;
            end else begin
                e_rel = 1'b1;
            end
            hist.delete();
        end else if (m_level) begin
            m_held++;
`ifdef KEY_REPEAT_EN
            if (samp && m_prev && m_held >= RD && ((m_held - RD) % RP) == 0) e_prs = 1'b1;
`endif
        end
        m_prev = samp;
    endtask

    task automatic step(input logic k);
        KEY = k;
        @(posedge CLK);
        model_edge(k);
        #1;
        chk("model_level", lvl, m_level);
        chk("model_press", prs, e_prs);
        chk("model_release", rel, e_rel);
    endtask

    // Asynchronous reset, asserted away from the clock edge; outputs must clear at once.
    task automatic apply_reset();
        RSTn = 1'b0;
        model_reset();
        #1;
        chk("rst_level", lvl, 1'b0);
        chk("rst_press", prs, 1'b0);
        chk("rst_release", rel, 1'b0);
        chk("rst_level0", lvl0, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("rst_no_release", rel, 1'b0);
            chk("rst_hold_level", lvl, 1'b0);
        end
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        int n;
        logic k;
        int len;

        for (int i = 0; i < 40; i++) begin
            tbl[i].pressed = (i < 20);
            tbl[i].e_lvl   = (i >= 6) && (i < 26);
            tbl[i].e_prs   = (i == 6);
`ifdef KEY_REPEAT_EN
            tbl[i].e_prs   = (i == 6) || (i == 16) || (i == 21);
`endif
            tbl[i].e_rel   = (i == 26);
        end

        #2;
        apply_reset();

        // Clean press then clean release on both polarities.
        for (int i = 0; i < 40; i++) begin
            KEY0 = tbl[i].pressed;
            step(~tbl[i].pressed);
            chk("tbl_level", lvl, tbl[i].e_lvl);
            chk("tbl_press", prs, tbl[i].e_prs);
            chk("tbl_release", rel, tbl[i].e_rel);
            chk("tbl_level_ah", lvl0, tbl[i].e_lvl);
            chk("tbl_press_ah", prs0, tbl[i].e_prs);
            chk("tbl_release_ah", rel0, tbl[i].e_rel);
        end
        KEY0 = 1'b0;

        // Press bounce: 0,1,0,1 every 2 cycles, then held.
        for (int t = 0; t < 8; t++) begin
            step(((t / 2) % 2) == 0 ? 1'b0 : 1'b1);
            chk("bounce_quiet", prs, 1'b0);
            chk("bounce_level", lvl, 1'b0);
        end
        for (int j = 1; j <= 12; j++) begin
            step(1'b0);
            chk("bounce_accept", prs, j == 7);
        end

        // Short release glitch must not disturb the level.
        for (int j = 0; j < 13; j++) begin
            step(j < 3 ? 1'b1 : 1'b0);
            chk("glitch_level", lvl, 1'b1);
            chk("glitch_release", rel, 1'b0);
        end

        for (int j = 1; j <= 12; j++) begin
            step(1'b1);
            chk("rel_pulse", rel, j == 7);
            chk("rel_level", lvl, j < 7);
        end

        // Reset while held, then re-qualification of the still-held key.
        for (int j = 0; j < 10; j++) step(1'b0);
        chk("pre_rst_down", lvl, 1'b1);
        apply_reset();
        n = 0;
        for (int j = 1; j <= 40; j++) begin
            step(1'b0);
            if (prs) n++;
            if (j == 7) chk("rst_repress", prs, 1'b1);
            if (j < 7) chk("rst_wait_level", lvl, 1'b0);
        end
`ifdef KEY_REPEAT_EN
        chk_int("held_press_count", n, 6);
`else
        chk_int("held_press_count", n, 1);
`endif
        for (int j = 0; j < 12; j++) step(1'b1);

        // Random bounce: mostly short runs with occasional long holds.
        repeat (300) begin
            k   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 30)) : int'($urandom_range(1, 5));
            repeat (len) step(k);
        end
        for (int j = 0; j < 12; j++) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
